// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared FP16 field widths, constants and multiplier FSM states
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int BIAS   = 15;

  localparam logic [EXP_W-1:0] EXP_MAX       = 5'h1f;
  localparam logic [15:0]      FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0]      FP16_QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_mul_normaliser.sv
// rtl/fp16_mul_normaliser.sv - packs the raw significand product into an FP16 result
module fp16_mul_normaliser
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic [EXP_W-1:0]  ea,
  input  logic [EXP_W-1:0]  eb,
  input  logic [PROD_W-1:0] prod,
  output logic [15:0]       result
);

  logic              zero_a, zero_b, inf_a, inf_b;
  logic signed [6:0] e_base, e_fin;
  logic [FRAC_W-1:0] frac;
  logic              unused_prod;

  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EXP_MAX);
  assign inf_b  = (eb == EXP_MAX);

  // Truncating normalisation: the product of two [1,2) significands is in [1,4)
  assign e_base = $signed({2'b00, ea} + {2'b00, eb} - 7'(BIAS));
  assign e_fin  = e_base + (prod[PROD_W-1] ? 7'sd1 : 7'sd0);
  assign frac   = prod[PROD_W-1] ? prod[20:11] : prod[19:10];

  assign unused_prod = ^prod[9:0];

  always_comb begin
    result = {sign, 15'h0000};
    if ((zero_a && inf_b) || (zero_b && inf_a)) begin
      result = FP16_QNAN;
    end else if (zero_a || zero_b) begin
      result = {sign, 15'h0000};
    end else if (inf_a || inf_b) begin
      result = {sign, FP16_POS_INF[14:0]};
    end else if (e_fin >= 7'sd31) begin
      result = {sign, FP16_POS_INF[14:0]};
    end else if (e_fin <= 7'sd0) begin
      result = {sign, 15'h0000};
    end else begin
      result = {sign, e_fin[EXP_W-1:0], frac};
    end
  end

endmodule

// File: rtl/fp16_seq_multiplier.sv
// rtl/fp16_seq_multiplier.sv - sequential shift-and-add FP16 multiplier with valid/ready handshakes
module fp16_seq_multiplier
  import fp16_pkg::*;
#(
  parameter int MUL_ITERS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  localparam int CNT_W = $clog2(MUL_ITERS + 1);

  state_t              state, state_nxt;
  logic                sign_q;
  logic [EXP_W-1:0]    ea_q, eb_q;
  logic [PROD_W-1:0]   mcand, prod;
  logic [SIG_W-1:0]    mplier;
  logic [CNT_W-1:0]    cnt;
  logic [15:0]         out_q;
  logic [15:0]         norm_result;
  logic                accept, mul_last;

  assign accept   = in_valid && in_ready;
  assign mul_last = (cnt == CNT_W'(MUL_ITERS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // MUL spends MUL_ITERS add cycles plus one terminal cycle, fixing the latency at 13 edges
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MUL;
      MUL:     if (mul_last)  state_nxt = NORM;
      NORM:                   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      ea_q   <= '0;
      eb_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (accept) begin
      sign_q <= a[15] ^ b[15];
      ea_q   <= a[14:10];
      eb_q   <= b[14:10];
      mcand  <= {{(PROD_W-SIG_W){1'b0}}, (a[14:10] != '0), a[9:0]};
      mplier <= {(b[14:10] != '0), b[9:0]};
      prod   <= '0;
      cnt    <= '0;
    end else if (state == MUL && !mul_last) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 16'h0000;
    end else if (state == NORM) begin
      out_q <= norm_result;
    end
  end

  assign out = out_q;

  fp16_mul_normaliser u_norm (
    .sign   (sign_q),
    .ea     (ea_q),
    .eb     (eb_q),
    .prod   (prod),
    .result (norm_result)
  );

endmodule

// File: doc/fp16_seq_multiplier.md
FP16_SEQ_MULTIPLIER -- requirements
Module: fp16_seq_multiplier

Interface
REQ-001 SHALL have parameter MUL_ITERS, default 11, number of shift-and-add iterations (one per significand bit).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts operands.
REQ-006 SHALL have port a  input  16  FP16 operand (sign, 5-bit exponent, 10-bit fraction).
REQ-007 SHALL have port b  input  16  FP16 operand.
REQ-008 SHALL have port out_valid  output  1  product on out is valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes product.
REQ-010 SHALL have port out  output  16  FP16 product a*b.
REQ-011 SHALL have one clock; reset SHALL be asynchronous and active-high.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, NORM, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE and 0 while rst is high.
REQ-014 SHALL accept on a clk edge where in_valid&&in_ready: latch sign=a[15]^b[15], exponents, and significands {hidden,frac}; hidden=1 for exponent!=0; go IDLE->MUL with iteration counter=0.
REQ-015 SHALL in MUL add the shifted multiplicand into a 22-bit product when the current multiplier bit is 1, one bit per cycle, LSB first, for MUL_ITERS cycles, then go to NORM.
REQ-016 SHALL in NORM (1 cycle) compute e=ea+eb-15 in 7-bit signed; if P[21]=1 then fraction=P[20:11] and e=e+1, else fraction=P[19:10]; truncate, no rounding.
REQ-017 SHALL produce exponent 31 with fraction 0 (signed infinity) when final e>=31.
REQ-018 SHALL produce signed zero when either input exponent field is 0 (flush-to-zero) or final e<=0.
REQ-019 SHALL produce infinity when either input exponent is 31 and neither is zero; SHALL produce 0x7E00 for infinity times zero.
REQ-020 SHALL hold constant latency regardless of operand values; out_valid SHALL rise on the 13th clk edge after the accepting edge.
REQ-021 SHALL in DONE hold out_valid=1 and out stable until an edge with out_ready=1, then go to IDLE; no new operand is accepted in the same cycle.
REQ-022 SHALL hold out at its last value and out_valid=0 outside DONE.

Reset
REQ-023 SHALL on rst, at any time including mid-MUL or DONE, asynchronously force state=IDLE, out_valid=0, out=16'h0000, product=0, counter=0; the in-flight operation SHALL be discarded.
REQ-024 SHALL accept a new operand pair on the first clk edge after rst deasserts.

Structure
REQ-025 SHALL place in shared package fp16_pkg: field widths, bias 15, FP16_POS_INF 16'h7C00, FP16_QNAN 16'h7E00, FSM state enum.
REQ-026 SHALL implement NORM exponent/fraction packing and special-case selection as combinational sub-module fp16_mul_normaliser; the FSM and datapath stay in the top module.

Verification
REQ-027 SHALL cover 0x3C00*0x4000 (1.0*2.0) -> out=0x4000, out_valid exactly 13 edges after acceptance.
REQ-028 SHALL cover 0x3E00*0x3E00 (1.5*1.5) -> 0x4080, and 0xC000*0x4200 (-2*3) -> 0xC600.
REQ-029 SHALL cover 0x7800*0x4000 -> 0x7C00 overflow; 0x8000*0x3C00 -> 0x8000; 0x0000*0x7C00 -> 0x7E00.
REQ-030 SHALL cover out_ready held low for 5 cycles in DONE -> out and out_valid stable, in_ready=0, with in_valid held high throughout.
REQ-031 SHALL cover rst pulse during MUL cycle 5 -> out_valid=0 and in_ready=1 after release; next op 0x4000*0x4000 -> 0x4400.
